// File: rtl/mem_port_arbiter_pkg.sv
// Types and helpers for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;
  `include "mem_arb_defs.vh"

  localparam int LD_CNT_W = 3;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  typedef struct packed {
    logic gnt_f;
    logic gnt_d;
  } arb_gnt_t;

  // Two-way round robin: a lone requester always wins, a conflict goes to the non-last owner.
  function automatic arb_gnt_t arb_pick(input logic req_f, input logic req_d, input logic last);
    arb_gnt_t g;
    g.gnt_f = req_f & (~req_d | (last == OWN_DATA));
    g.gnt_d = req_d & (~req_f | (last == OWN_FETCH));
    return g;
  endfunction
endpackage

// File: rtl/mem_arb_defs.vh
// Owner encodings and tag width shared by the memory-port arbiters.
`ifndef MEM_ARB_DEFS_VH
`define MEM_ARB_DEFS_VH
localparam logic OWN_FETCH = 1'b0;
localparam logic OWN_DATA  = 1'b1;
localparam int   ARB_TAG_W = 2;
`endif

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, owner} for each issued read until its data returns.
module rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic clr_n,
  input  logic push_valid,
  input  logic push_owner,
  output logic pop_valid,
  output logic pop_owner
);
  rd_tag_t [RD_LAT-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= '{valid: push_valid, owner: push_owner};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign pop_valid = r_pipe[RD_LAT-1].valid;
  assign pop_owner = r_pipe[RD_LAT-1].owner;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined single-port memory between instruction fetch and data ports.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              core_stall
);
  logic                r_last_owner;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic [LD_CNT_W-1:0] r_ld_cnt;

  arb_gnt_t w_gnt;
  logic     w_pop_valid;
  logic     w_pop_owner;
  logic     w_ld_issue;

  always_comb begin
    w_gnt = arb_pick(if_req, d_req, r_last_owner);
    if (!rst_n) w_gnt = '0;
  end

  assign if_gnt     = w_gnt.gnt_f;
  assign d_gnt      = w_gnt.gnt_d;
  assign m_en       = w_gnt.gnt_f | w_gnt.gnt_d;
  assign m_we       = w_gnt.gnt_d & d_we;
  assign w_ld_issue = w_gnt.gnt_d & ~d_we;

  // Address and write data hold their last value when idle to avoid bus toggling.
  always_comb begin
    m_addr  = r_m_addr;
    m_wdata = r_m_wdata;
    if (w_gnt.gnt_f) begin
      m_addr = if_addr;
    end else if (w_gnt.gnt_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk        (clk),
    .clr_n      (rst_n),
    .push_valid (m_en & ~m_we),
    .push_owner (w_gnt.gnt_d ? OWN_DATA : OWN_FETCH),
    .pop_valid  (w_pop_valid),
    .pop_owner  (w_pop_owner)
  );

  assign if_rvalid = w_pop_valid & (w_pop_owner == OWN_FETCH);
  assign d_rvalid  = w_pop_valid & (w_pop_owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? m_rdata : r_if_rdata;
  assign d_rdata   = d_rvalid  ? m_rdata : r_d_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_owner <= OWN_DATA;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_ld_cnt     <= '0;
    end else begin
      if (w_gnt.gnt_f)      r_last_owner <= OWN_FETCH;
      else if (w_gnt.gnt_d) r_last_owner <= OWN_DATA;
      r_m_addr   <= m_addr;
      r_m_wdata  <= m_wdata;
      r_if_rdata <= if_rdata;
      r_d_rdata  <= d_rdata;
      // Outstanding loads, counted from grant through the d_rvalid cycle.
      case ({w_ld_issue, d_rvalid})
        2'b10:   r_ld_cnt <= r_ld_cnt + LD_CNT_W'(1);
        2'b01:   r_ld_cnt <= r_ld_cnt - LD_CNT_W'(1);
        default: r_ld_cnt <= r_ld_cnt;
      endcase
    end
  end

  assign core_stall = rst_n & ((if_req & ~if_gnt) | (d_req & ~d_gnt) |
                               (r_ld_cnt != '0) | w_ld_issue);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (RD_LAT 1 and 3) on shared stimulus, each with its own memory.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, preload;
  logic if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;

  logic if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1, stall1;
  logic [AW-1:0] m_addr1;
  logic [DW-1:0] if_rdata1, d_rdata1, m_wdata1, m_rdata1;
  logic if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, m_en3, m_we3, stall3;
  logic [AW-1:0] m_addr3;
  logic [DW-1:0] if_rdata3, d_rdata3, m_wdata3, m_rdata3;

  int n_cmp, n_err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1),
    .core_stall(stall1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_rdata(m_rdata3),
    .core_stall(stall3)
  );

  // Memory models: mem[i] = 0x100+i after preload, reads delayed by 1 and 3 cycles.
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd3 [3];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 32'h100 + 32'(i);
        mem3[i] <= 32'h100 + 32'(i);
      end
    end else begin
      if (m_en1 && m_we1) mem1[m_addr1[7:0]] <= m_wdata1;
      if (m_en3 && m_we3) mem3[m_addr3[7:0]] <= m_wdata3;
    end
    rd1    <= mem1[m_addr1[7:0]];
    rd3[0] <= mem3[m_addr3[7:0]];
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign m_rdata1 = rd1;
  assign m_rdata3 = rd3[2];

  task automatic idle(input int n);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h20; d_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({if_gnt1, d_gnt1, m_en1, m_we1, stall1, if_gnt3, d_gnt3, m_en3, m_we3, stall3} !== 10'b0) begin
        n_err++;
        $display("FAIL reset_outs c%0d got gnt/en/stall %b%b%b%b%b %b%b%b%b%b want all 0", k,
                 if_gnt1, d_gnt1, m_en1, m_we1, stall1, if_gnt3, d_gnt3, m_en3, m_we3, stall3);
      end
      if (k > 0) begin
        n_cmp++;
        if ({if_rvalid1, d_rvalid1, if_rvalid3, d_rvalid3} !== 4'b0) begin
          n_err++;
          $display("FAIL reset_rvalid c%0d got %b%b%b%b want 0000", k,
                   if_rvalid1, d_rvalid1, if_rvalid3, d_rvalid3);
        end
      end
      @(posedge clk); #1;
      preload = 1'b0;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({if_gnt1, d_gnt1, if_gnt3, d_gnt3} !== 4'b1010) begin
      n_err++;
      $display("FAIL reset_first_gnt got %b%b%b%b want 1010", if_gnt1, d_gnt1, if_gnt3, d_gnt3);
    end
    n_cmp++;
    if (m_addr1 !== 32'h0 || stall1 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_first_maddr_stall got %h/%b want 00000000/1", m_addr1, stall1);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d_gnt1 !== 1'b1 || if_rvalid1 !== 1'b1 || if_rdata1 !== 32'h100) begin
      n_err++;
      $display("FAIL reset_second got d_gnt=%b if_rvalid=%b if_rdata=%h want 1/1/00000100",
               d_gnt1, if_rvalid1, if_rdata1);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d_rvalid1 !== 1'b1 || d_rdata1 !== 32'h120 || stall1 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_load_ret got d_rvalid=%b d_rdata=%h stall=%b want 1/00000120/1",
               d_rvalid1, d_rdata1, stall1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (stall1 !== 1'b0 || d_rvalid1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_stall_clear got stall=%b d_rvalid=%b want 0/0", stall1, d_rvalid1);
    end
    idle(4);
  endtask

  task automatic test_conflict();
    int ireq [6] = '{1, 1, 1, 1, 1, 0};
    int dreq [6] = '{1, 1, 1, 1, 0, 0};
    logic [31:0] iad [6] = '{32'h8, 32'h9, 32'h9, 32'hA, 32'hA, 32'hA};
    int e_ig [6] = '{1, 0, 1, 0, 1, 0};
    int e_dg [6] = '{0, 1, 0, 1, 0, 0};
    int e_irv [6] = '{0, 1, 0, 1, 0, 1};
    int e_drv [6] = '{0, 0, 1, 0, 1, 0};
    int e_st [6] = '{1, 1, 1, 1, 1, 0};
    logic [31:0] e_ird [6] = '{32'h0, 32'h108, 32'h0, 32'h109, 32'h0, 32'h10A};
    d_we = 1'b0; d_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      if_req = ireq[c][0]; d_req = dreq[c][0]; if_addr = iad[c];
      @(negedge clk);
      n_cmp++;
      if (if_gnt1 !== e_ig[c][0] || d_gnt1 !== e_dg[c][0]) begin
        n_err++;
        $display("FAIL conflict_gnt c%0d got F%b D%b want F%0d D%0d", c, if_gnt1, d_gnt1, e_ig[c], e_dg[c]);
      end
      n_cmp++;
      if (stall1 !== e_st[c][0]) begin
        n_err++;
        $display("FAIL conflict_stall c%0d got %b want %0d", c, stall1, e_st[c]);
      end
      n_cmp++;
      if (if_rvalid1 !== e_irv[c][0] || d_rvalid1 !== e_drv[c][0]) begin
        n_err++;
        $display("FAIL conflict_rvalid c%0d got if%b d%b want if%0d d%0d", c, if_rvalid1, d_rvalid1,
                 e_irv[c], e_drv[c]);
      end
      if (e_irv[c] == 1) begin
        n_cmp++;
        if (if_rdata1 !== e_ird[c]) begin
          n_err++;
          $display("FAIL conflict_if_rdata c%0d got %h want %h", c, if_rdata1, e_ird[c]);
        end
      end
      if (e_drv[c] == 1) begin
        n_cmp++;
        if (d_rdata1 !== 32'h120) begin
          n_err++;
          $display("FAIL conflict_d_rdata c%0d got %h want 00000120", c, d_rdata1);
        end
      end
      if (c < 5) begin
        n_cmp++;
        if (m_addr1 !== (e_dg[c] == 1 ? 32'h20 : iad[c])) begin
          n_err++;
          $display("FAIL conflict_maddr c%0d got %h", c, m_addr1);
        end
      end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_fetch_stream();
    for (int c = 0; c < 5; c++) begin
      if_req = (c < 4); d_req = 1'b0;
      if_addr = (c < 4) ? 32'(c) : 32'h3;
      @(negedge clk);
      n_cmp++;
      if (if_gnt1 !== (c < 4) || stall1 !== 1'b0) begin
        n_err++;
        $display("FAIL fetch_gnt_stall c%0d got gnt=%b stall=%b want %0d/0", c, if_gnt1, stall1, (c < 4));
      end
      if (c < 4) begin
        n_cmp++;
        if (m_addr1 !== 32'(c) || m_en1 !== 1'b1 || m_we1 !== 1'b0) begin
          n_err++;
          $display("FAIL fetch_mem c%0d got addr=%h en=%b we=%b want %h/1/0", c, m_addr1, m_en1, m_we1, 32'(c));
        end
      end
      n_cmp++;
      if (if_rvalid1 !== (c > 0)) begin
        n_err++;
        $display("FAIL fetch_rvalid c%0d got %b want %0d", c, if_rvalid1, (c > 0));
      end
      if (c > 0) begin
        n_cmp++;
        if (if_rdata1 !== 32'h100 + 32'(c - 1)) begin
          n_err++;
          $display("FAIL fetch_rdata c%0d got %h want %h", c, if_rdata1, 32'h100 + 32'(c - 1));
        end
      end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_store_load();
    d_addr = 32'h40; d_wdata = 32'hDEADBEEF; if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (d_gnt1 !== 1'b1 || m_en1 !== 1'b1 || m_we1 !== 1'b1 || m_wdata1 !== 32'hDEADBEEF || stall1 !== 1'b0) begin
      n_err++;
      $display("FAIL store_issue got gnt=%b en=%b we=%b wdata=%h stall=%b want 1/1/1/deadbeef/0",
               d_gnt1, m_en1, m_we1, m_wdata1, stall1);
    end
    @(posedge clk); #1;
    d_we = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d_gnt1 !== 1'b1 || m_we1 !== 1'b0 || d_rvalid1 !== 1'b0 || d_rdata1 !== 32'h120) begin
      n_err++;
      $display("FAIL load_issue got gnt=%b we=%b rvalid=%b rdata=%h want 1/0/0/00000120",
               d_gnt1, m_we1, d_rvalid1, d_rdata1);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (d_rvalid1 !== 1'b1 || d_rdata1 !== 32'hDEADBEEF || stall1 !== 1'b1) begin
      n_err++;
      $display("FAIL load_return got rvalid=%b rdata=%h stall=%b want 1/deadbeef/1", d_rvalid1, d_rdata1, stall1);
    end
    n_cmp++;
    if (m_en1 !== 1'b0 || m_we1 !== 1'b0 || m_addr1 !== 32'h40) begin
      n_err++;
      $display("FAIL idle_hold got en=%b we=%b addr=%h want 0/0/00000040", m_en1, m_we1, m_addr1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (d_rvalid1 !== 1'b0 || stall1 !== 1'b0 || d_rdata1 !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL load_after got rvalid=%b stall=%b rdata=%h want 0/0/deadbeef", d_rvalid1, stall1, d_rdata1);
    end
    idle(4);
  endtask

  task automatic test_lat3();
    int ireq [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    int dreq [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] iad [8] = '{32'h10, 32'h11, 32'h11, 32'h11, 32'h11, 32'h11, 32'h11, 32'h11};
    logic [31:0] dad [8] = '{32'h30, 32'h30, 32'h31, 32'h31, 32'h31, 32'h31, 32'h31, 32'h31};
    int e_ig [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    int e_dg [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    int e_irv [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    int e_drv [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    logic [31:0] e_rd [8] = '{32'h0, 32'h0, 32'h0, 32'h110, 32'h130, 32'h111, 32'h131, 32'h0};
    d_we = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if_req = ireq[c][0]; d_req = dreq[c][0]; if_addr = iad[c]; d_addr = dad[c];
      @(negedge clk);
      n_cmp++;
      if (if_gnt3 !== e_ig[c][0] || d_gnt3 !== e_dg[c][0]) begin
        n_err++;
        $display("FAIL lat3_gnt c%0d got F%b D%b want F%0d D%0d", c, if_gnt3, d_gnt3, e_ig[c], e_dg[c]);
      end
      n_cmp++;
      if (if_rvalid3 !== e_irv[c][0] || d_rvalid3 !== e_drv[c][0]) begin
        n_err++;
        $display("FAIL lat3_rvalid c%0d got if%b d%b want if%0d d%0d", c, if_rvalid3, d_rvalid3,
                 e_irv[c], e_drv[c]);
      end
      if (e_irv[c] == 1) begin
        n_cmp++;
        if (if_rdata3 !== e_rd[c]) begin
          n_err++;
          $display("FAIL lat3_if_rdata c%0d got %h want %h", c, if_rdata3, e_rd[c]);
        end
      end
      if (e_drv[c] == 1) begin
        n_cmp++;
        if (d_rdata3 !== e_rd[c]) begin
          n_err++;
          $display("FAIL lat3_d_rdata c%0d got %h want %h", c, d_rdata3, e_rd[c]);
        end
      end
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  task automatic test_reset_midflight();
    int rstv [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    int ireq [9] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
    int dreq [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] iad [9] = '{32'h60, 32'h60, 32'h62, 32'h62, 32'h62, 32'h62, 32'h62, 32'h62, 32'h62};
    logic [31:0] dad [9] = '{32'h50, 32'h50, 32'h51, 32'h51, 32'h51, 32'h51, 32'h51, 32'h51, 32'h51};
    int e_ig [9] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
    int e_dg [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    int e_irv [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    int e_drv [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    d_we = 1'b0;
    for (int c = 0; c < 9; c++) begin
      rst_n = rstv[c][0]; if_req = ireq[c][0]; d_req = dreq[c][0];
      if_addr = iad[c]; d_addr = dad[c];
      @(negedge clk);
      n_cmp++;
      if (if_gnt3 !== e_ig[c][0] || d_gnt3 !== e_dg[c][0]) begin
        n_err++;
        $display("FAIL midrst_gnt c%0d got F%b D%b want F%0d D%0d", c, if_gnt3, d_gnt3, e_ig[c], e_dg[c]);
      end
      if (c >= 2) begin
        n_cmp++;
        if (if_rvalid3 !== e_irv[c][0] || d_rvalid3 !== e_drv[c][0]) begin
          n_err++;
          $display("FAIL midrst_rvalid c%0d got if%b d%b want if%0d d%0d", c, if_rvalid3, d_rvalid3,
                   e_irv[c], e_drv[c]);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (m_en3 !== 1'b0 || stall3 !== 1'b0) begin
          n_err++;
          $display("FAIL midrst_forced got en=%b stall=%b want 0/0", m_en3, stall3);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (if_rdata3 !== 32'h162) begin
          n_err++;
          $display("FAIL midrst_if_rdata got %h want 00000162", if_rdata3);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (d_rdata3 !== 32'h151 || stall3 !== 1'b1) begin
          n_err++;
          $display("FAIL midrst_d_ret got rdata=%h stall=%b want 00000151/1", d_rdata3, stall3);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (stall3 !== 1'b0) begin
          n_err++;
          $display("FAIL midrst_stall_end got %b want 0", stall3);
        end
      end
      @(posedge clk); #1;
    end
    idle(2);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    preload = 1'b1; rst_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    #1;
    test_reset();
    test_conflict();
    test_fetch_stream();
    test_store_load();
    test_lat3();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
